// File: rtl/fetch_if.sv
// Fetch-stage bus: control inputs, instruction memory port and IF/ID outputs.
// The slave modport is the fetch stage; master is its environment.
interface fetch_if;
  logic        start_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] branch_target_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic [31:0] pc_o;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_instr_o;
  logic        if_id_valid_o;
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;

  modport slave (
    input  start_i, stall_i, flush_i, branch_target_i, imem_instr_i,
    output imem_addr_o, pc_o, if_id_pc_o, if_id_instr_o, if_id_valid_o,
           stall_cnt_o, flush_cnt_o
  );

  modport master (
    output start_i, stall_i, flush_i, branch_target_i, imem_instr_i,
    input  imem_addr_o, pc_o, if_id_pc_o, if_id_instr_o, if_id_valid_o,
           stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register plus IF/ID pipeline register.
// Define FETCH_PERF_CNT_EN to build the saturating stall/flush counters.
module fetch_stage (
  input  logic   clk_i,
  input  logic   rst_i,
  fetch_if.slave bus
);

  logic [31:0] pc_p0;
  logic [31:0] pc_p1;
  logic [31:0] instr_p1;
  logic        vld_p1;
  logic        unused_tgt;

  // Redirect targets are word aligned, so the low bits are dropped.
  assign unused_tgt = ^bus.branch_target_i[1:0];

  // Stage 0: fetch PC
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_p0 <= 32'd0;
    end else if (bus.start_i) begin
      if (bus.flush_i)
        pc_p0 <= {bus.branch_target_i[31:2], 2'b00};
      else if (!bus.stall_i)
        pc_p0 <= pc_p0 + 32'd4;
    end
  end

  // Stage 1: IF/ID register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_p1    <= 32'd0;
      instr_p1 <= 32'd0;
      vld_p1   <= 1'b0;
    end else if (bus.start_i) begin
      if (bus.flush_i) begin
        pc_p1    <= 32'd0;
        instr_p1 <= 32'd0;
        vld_p1   <= 1'b0;
      end else if (!bus.stall_i) begin
        pc_p1    <= pc_p0;
        instr_p1 <= bus.imem_instr_i;
        vld_p1   <= 1'b1;
      end
    end
  end

  assign bus.imem_addr_o   = pc_p0;
  assign bus.pc_o          = pc_p0;
  assign bus.if_id_pc_o    = pc_p1;
  assign bus.if_id_instr_o = instr_p1;
  assign bus.if_id_valid_o = vld_p1;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_p1;
  logic [31:0] flush_cnt_p1;

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  // Performance counters; a flush-and-stall cycle counts as a flush only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_p1 <= 32'd0;
      flush_cnt_p1 <= 32'd0;
    end else if (bus.start_i) begin
      if (bus.flush_i)
        flush_cnt_p1 <= sat_inc(flush_cnt_p1);
      else if (bus.stall_i)
        stall_cnt_p1 <= sat_inc(stall_cnt_p1);
    end
  end

  assign bus.stall_cnt_o = stall_cnt_p1;
  assign bus.flush_cnt_o = flush_cnt_p1;
`else
  assign bus.stall_cnt_o = 32'd0;
  assign bus.flush_cnt_o = 32'd0;
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-high reset: clk_i  in  1  rising-edge clock; rst_i  in  1  synchronous active-high reset.
REQ-002 start_i  in  1  run enable; 0 = freeze PC and IF/ID state.
REQ-003 stall_i  in  1  hazard stall request from ID (load-use).
REQ-004 flush_i  in  1  branch taken in ID; redirect PC and squash IF/ID.
REQ-005 branch_target_i  in  32  redirect address, valid when flush_i=1.
REQ-006 imem_addr_o  out  32  instruction memory byte address.
REQ-007 imem_instr_i  in  32  instruction word returned combinationally for imem_addr_o.
REQ-008 pc_o  out  32  current fetch PC.
REQ-009 if_id_pc_o  out  32  IF/ID register: PC of the held instruction.
REQ-010 if_id_instr_o  out  32  IF/ID register: held instruction word.
REQ-011 if_id_valid_o  out  1  IF/ID register holds a real instruction, not a bubble.
REQ-012 stall_cnt_o  out  32  count of stalled cycles.
REQ-013 flush_cnt_o  out  32  count of flush cycles.

Function
REQ-014 imem_addr_o SHALL equal pc_o combinationally, with zero cycles of latency.
REQ-015 PC update on each rising edge with start_i=1, in priority order: flush_i=1 -> {branch_target_i[31:2],2'b00}; else stall_i=1 -> hold; else pc_o+4.
REQ-016 PC increment SHALL wrap modulo 2^32 (0xFFFFFFFC+4 -> 0x00000000), with no error indication.
REQ-017 IF/ID update with start_i=1: flush_i=1 -> pc=0, instr=0, valid=0 (bubble); else stall_i=1 -> hold all three; else pc<=pc_o, instr<=imem_instr_i, valid<=1.
REQ-018 Fetch latency: the instruction at PC p SHALL appear on if_id_* exactly one cycle after pc_o=p, provided there is no stall or flush.
REQ-019 Simultaneous flush_i=1 and stall_i=1: flush SHALL win for both PC and IF/ID, and the cycle SHALL count as a flush only.
REQ-020 start_i=0: PC, IF/ID and both counters SHALL hold regardless of stall_i and flush_i.
REQ-021 stall_cnt_o SHALL increment by 1 on each edge with start_i=1, stall_i=1 and flush_i=0.
REQ-022 flush_cnt_o SHALL increment by 1 on each edge with start_i=1 and flush_i=1.
REQ-023 Both counters SHALL saturate at 0xFFFFFFFF rather than wrap.
REQ-024 Inputs on cycles where start_i=0 SHALL have no effect on any state, including pending flush requests, which are not remembered.

Reset
REQ-025 rst_i=1 at a rising edge SHALL force pc_o=0, if_id_pc_o=0, if_id_instr_o=0, if_id_valid_o=0, stall_cnt_o=0 and flush_cnt_o=0.
REQ-026 Reset SHALL take precedence over start_i, stall_i and flush_i.
REQ-027 Reset asserted mid-operation SHALL discard an in-flight redirect, and the first fetch after release SHALL be at address 0.
REQ-028 Outputs SHALL be stable and defined (no X) from the first edge with rst_i=1.

Configuration
REQ-029 Macro FETCH_PERF_CNT_EN defined: both counters SHALL be implemented per REQ-021..REQ-023.
REQ-030 FETCH_PERF_CNT_EN undefined: no counter flops SHALL be instantiated, stall_cnt_o and flush_cnt_o SHALL be tied to 0, and all other behaviour SHALL be unchanged.

Verification
REQ-031 Reset, then start_i=1 for 4 cycles with no hazards, imem returning 0x00000013 -> pc_o sequence 0,4,8,12; if_id_pc_o 0,4,8 with valid=1 one cycle behind.
REQ-032 Stall: at pc_o=8, hold stall_i=1 for 2 cycles -> pc_o stays 8 and IF/ID holds pc=4 for 2 cycles, then resumes 12; stall_cnt_o=2.
REQ-033 Flush: at pc_o=16, assert flush_i=1 with branch_target_i=0x00000041 -> next pc_o=0x40, if_id_valid_o=0, if_id_instr_o=0; flush_cnt_o=1.
REQ-034 Simultaneous stall_i=1 and flush_i=1 with target 0x20 -> pc_o=0x20, bubble in IF/ID; stall_cnt_o unchanged, flush_cnt_o+1.
REQ-035 start_i=0 for 3 cycles with stall_i and flush_i toggling -> no change to any output; then rst_i=1 mid-run -> all outputs 0 on the next edge.
REQ-036 Build with FETCH_PERF_CNT_EN undefined and rerun REQ-032 -> pc and IF/ID traces identical to the first run, with stall_cnt_o=0 throughout.
